goal_detector: RTL
==================

GOAL_DETECTOR -- requirements
Module: goal_detector

Interface
REQ-001 Parameter TOP_LIMIT, default 10'd8: ball_y at or below this value means the ball passed the top bar.
REQ-002 Parameter BOTTOM_LIMIT, default 10'd472: ball_y at or above this value means the ball passed the bottom bar.
REQ-003 Parameter HOLD_FRAMES, default 60: number of frames the ball stays frozen after a goal.
REQ-004 Parameter WIN_SCORE, default 7'd99: score at which a player wins the match.
REQ-005 clk_50  input  1  system clock, 50 MHz.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 frame_tick  input  1  one-cycle pulse per frame, synchronous to clk_50.
REQ-008 ball_y  input  10  ball top-edge row; valid whenever frame_tick is high.
REQ-009 start_ball  input  1  raw serve button, asynchronous to clk_50.
REQ-010 score_checker1  output  1  one-cycle pulse: player 1 (top bar) scored.
REQ-011 score_checker2  output  1  one-cycle pulse: player 2 (bottom bar) scored.
REQ-012 ball_freeze  output  1  high while the ball must not move.
REQ-013 serve_ready  output  1  high while waiting for a serve.
REQ-014 game_over  output  1  high once a player reaches WIN_SCORE.
REQ-015 winner  output  2  2'b01 = player 1, 2'b10 = player 2, 2'b00 = none.

Function
REQ-016 start_ball shall pass through a 2-flop synchronizer followed by a rising-edge detector; the serve event is one cycle long.
REQ-017 The FSM shall have four states: SERVE, PLAY, HOLD and OVER.
REQ-018 SERVE: serve_ready=1 and ball_freeze=1; a serve event moves the FSM to PLAY on the next clock.
REQ-019 PLAY: serve_ready=0 and ball_freeze=0; ball_y is evaluated only in cycles where frame_tick=1.
REQ-020 PLAY with frame_tick=1 and ball_y>=BOTTOM_LIMIT: assert score_checker1 for exactly one cycle and go to HOLD.
REQ-021 PLAY with frame_tick=1 and ball_y<=TOP_LIMIT (BOTTOM_LIMIT check not met): assert score_checker2 for exactly one cycle and go to HOLD.
REQ-022 If both limit conditions are true at once, the bottom check wins; at most one score pulse is issued per goal.
REQ-023 Scoring pulses shall be registered, appearing in the cycle after the qualifying frame_tick; no two pulses are ever high together.
REQ-024 Each player has a 7-bit shadow score; it increments in the same cycle as that player's pulse and saturates at WIN_SCORE.
REQ-025 HOLD: ball_freeze=1; a frame counter counts frame_tick pulses from 0 and, on reaching HOLD_FRAMES-1, moves the FSM to SERVE.
REQ-026 HOLD exit override: if either shadow score equals WIN_SCORE on entry to HOLD, the FSM goes to OVER instead of SERVE at the end of HOLD.
REQ-027 OVER: game_over=1, ball_freeze=1, serve_ready=0, winner set from the shadow score equal to WIN_SCORE; no further pulses; only reset leaves OVER.
REQ-028 Serve events outside SERVE shall be ignored.
REQ-029 frame_tick in SERVE or OVER shall not change any state.

Reset
REQ-030 Reset shall immediately force: SERVE state, score_checker1=0, score_checker2=0, ball_freeze=1, serve_ready=1, game_over=0, winner=2'b00, shadow scores=0, frame counter=0, synchronizer flops=0.
REQ-031 Reset asserted mid-PLAY or mid-HOLD shall abort without any score pulse; after release the block waits for a new serve.

Verification
REQ-032 Reset, then raise start_ball -> serve_ready falls and FSM enters PLAY within 4 clocks; ball_freeze=0.
REQ-033 PLAY, frame_tick with ball_y=480 held for 3 frames -> exactly one score_checker1 pulse, ball_freeze=1, serve_ready=1 after 60 frame_ticks.
REQ-034 PLAY, frame_tick with ball_y=5 -> one score_checker2 pulse one cycle later; ball_y=5 with frame_tick=0 -> no pulse.
REQ-035 Hold start_ball high during HOLD, and press it in PLAY -> no state change; only a fresh rising edge in SERVE starts play.
REQ-036 With WIN_SCORE=3, player 1 scores three times -> after the third HOLD: game_over=1, winner=2'b01; further goals produce no pulses; reset clears everything.
REQ-037 Assert reset two frames into HOLD -> no pulse, all outputs at reset values, shadow scores=0.

Source files
------------

// File: rtl/goal_detector.sv
// Pong goal detector: watches the ball row each frame, issues one registered score
// pulse per goal, freezes the ball for a hold period and tracks the match winner.
module goal_detector #(
  parameter logic [9:0] TOP_LIMIT    = 10'd8,
  parameter logic [9:0] BOTTOM_LIMIT = 10'd472,
  parameter int         HOLD_FRAMES  = 60,
  parameter logic [6:0] WIN_SCORE    = 7'd99
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [9:0] ball_y,
  input  logic       start_ball,
  output logic       score_checker1,
  output logic       score_checker2,
  output logic       ball_freeze,
  output logic       serve_ready,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [1:0] dbg_state
);

  localparam int CW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            prev_q, prev_d;
  logic            pulse1_q, pulse1_d;
  logic            pulse2_q, pulse2_d;
  logic [6:0]      score1_q, score1_d;
  logic [6:0]      score2_q, score2_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic serve_evt;
  logic goal_bottom;
  logic goal_top;
  logic won;

  assign serve_evt   = sync2_q & ~prev_q;
  // The bottom bar takes priority when both limits are satisfied in one frame.
  assign goal_bottom = frame_tick && (ball_y >= BOTTOM_LIMIT);
  assign goal_top    = frame_tick && (ball_y <= TOP_LIMIT) && !goal_bottom;
  assign won         = (score1_q == WIN_SCORE) || (score2_q == WIN_SCORE);

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q  <= ST_SERVE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      pulse1_q <= 1'b0;
      pulse2_q <= 1'b0;
      score1_q <= 7'd0;
      score2_q <= 7'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      pulse1_q <= pulse1_d;
      pulse2_q <= pulse2_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sync1_d  = start_ball;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    pulse1_d = 1'b0;
    pulse2_d = 1'b0;
    score1_d = score1_q;
    score2_d = score2_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_SERVE: begin
        if (serve_evt) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (goal_bottom) begin
          pulse1_d = 1'b1;
          score1_d = (score1_q >= WIN_SCORE) ? WIN_SCORE : score1_q + 7'd1;
          cnt_d    = '0;
          state_d  = ST_HOLD;
        end else if (goal_top) begin
          pulse2_d = 1'b1;
          score2_d = (score2_q >= WIN_SCORE) ? WIN_SCORE : score2_q + 7'd1;
          cnt_d    = '0;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Scores are settled on entry to HOLD, so the win test at exit sees the entry values.
        if (frame_tick) begin
          if (cnt_q == CW'(HOLD_FRAMES - 1)) begin
            cnt_d   = '0;
            state_d = won ? ST_OVER : ST_SERVE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    score_checker1 = pulse1_q;
    score_checker2 = pulse2_q;
    ball_freeze    = (state_q != ST_PLAY);
    serve_ready    = (state_q == ST_SERVE);
    game_over      = (state_q == ST_OVER);
    winner         = 2'b00;
    if (state_q == ST_OVER) winner = {score2_q == WIN_SCORE, score1_q == WIN_SCORE};
    dbg_state      = state_q;
  end

endmodule
